// File: rtl/awb_pkg.sv
// Shared widths, state encoding and pixel helpers for the gray-world white-balance block.
package awb_pkg;

    localparam int unsigned SUM_W     = 32;
    localparam int unsigned FRAC_W    = 8;
    localparam int unsigned GAIN_W    = 10;
    localparam int unsigned PIX_W     = 24;
    localparam int unsigned CH_W      = 8;
    localparam int unsigned PROD_W    = CH_W + GAIN_W;
    localparam int unsigned SUMX_W    = SUM_W + 1;
    localparam int unsigned DIV_W     = SUM_W + FRAC_W;
    localparam int unsigned CNT_W     = $clog2(DIV_W + 1);
    localparam int unsigned GAIN_ONE  = 256;
    localparam int unsigned GAIN_MAX  = 1023;
    localparam int unsigned GAIN_MIN  = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_R,
        ST_DIV_B,
        ST_UPDATE
    } awb_state_e;

    function automatic logic [CH_W-1:0] pix_r(input logic [PIX_W-1:0] p);
        return p[23:16];
    endfunction

    function automatic logic [CH_W-1:0] pix_g(input logic [PIX_W-1:0] p);
        return p[15:8];
    endfunction

    function automatic logic [CH_W-1:0] pix_b(input logic [PIX_W-1:0] p);
        return p[7:0];
    endfunction

    // Saturating accumulate: sticks at all-ones instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                 input logic [CH_W-1:0]  px);
        logic [SUMX_W-1:0] s;
        s = {1'b0, acc} + SUMX_W'(px);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    // Round a Q.8 product back to 8 bits, saturating at 255.
    function automatic logic [CH_W-1:0] sat8(input logic [PROD_W-1:0] p);
        logic [PROD_W:0] s;
        s = {1'b0, p} + (PROD_W + 1)'(128);
        return (|s[PROD_W:16]) ? '1 : s[15:8];
    endfunction

    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [DIV_W-1:0] q,
                                                     input logic             dz);
        if (dz)
            return GAIN_W'(GAIN_ONE);
        else if (q > DIV_W'(GAIN_MAX))
            return GAIN_W'(GAIN_MAX);
        else if (q < DIV_W'(GAIN_MIN))
            return GAIN_W'(GAIN_MIN);
        else
            return q[GAIN_W-1:0];
    endfunction

endpackage

// File: rtl/awb_gray_world_div.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle; start overrides abort.
module awb_gray_world_div
    import awb_pkg::*;
(
    input  logic               pre_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DIV_W-1:0]   dividend,
    input  logic [SUM_W-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [DIV_W-1:0]   quotient,
    output logic               div_zero
);

    logic [SUM_W:0]   rem;
    logic [SUM_W:0]   rem_sh;
    logic [SUM_W:0]   diff;
    logic [SUM_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             take;

    // Quotient shifts out its MSB into the partial remainder as result bits shift in.
    always_comb begin
        rem_sh = {rem[SUM_W-1:0], quotient[DIV_W-1]};
        diff   = rem_sh - {1'b0, dvs};
        take   = (rem_sh >= {1'b0, dvs});
    end

    always_ff @(posedge pre_clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            quotient <= '0;
            dvs      <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy     <= 1'b1;
                cnt      <= CNT_W'(DIV_W);
                rem      <= '0;
                quotient <= dividend;
                dvs      <= divisor;
                div_zero <= (divisor == '0);
            end else if (abort) begin
                busy <= 1'b0;
            end else if (busy) begin
                rem      <= take ? diff : rem_sh;
                quotient <= {quotient[DIV_W-2:0], take};
                cnt      <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/awb_gray_world.sv
// Gray-world auto white balance: per-frame RGB sums -> R/B gains (G unity) -> 2-stage gain pipeline.
module awb_gray_world
    import awb_pkg::*;
(
    input  logic              pre_clk,
    input  logic              rst_n,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              awb_en,
    output logic              out_vs,
    output logic              out_de,
    output logic [PIX_W-1:0]  out_data,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              div_abort
);

    awb_state_e        state, state_nx;
    logic              in_vs_d;
    logic              fs_c;
    logic [SUM_W-1:0]  acc_r, acc_g, acc_b;
    logic [SUM_W-1:0]  snap_g, snap_b;
    logic              en_act;
    logic [GAIN_W-1:0] hold_r, hold_b;
    logic [GAIN_W-1:0] pending_r, pending_b;
    logic              pending_valid;

    logic              div_start_c, div_abort_c, div_kill_c;
    logic              hold_r_we_c, hold_b_we_c, pend_we_c;
    logic [DIV_W-1:0]  dividend_c;
    logic [SUM_W-1:0]  divisor_c;
    logic              div_busy, div_done, div_zero;
    logic [DIV_W-1:0]  div_q;

    logic [GAIN_W-1:0] gr_c, gb_c;
    logic [PROD_W-1:0] s1_r, s1_b;
    logic [CH_W-1:0]   s1_g;
    logic              s1_vs, s1_de;

    assign fs_c       = in_vs & ~in_vs_d;
    assign div_kill_c = fs_c & div_busy;

    // Statistics: the fs-cycle pixel already belongs to the new frame.
    always_ff @(posedge pre_clk) begin
        if (!rst_n) begin
            in_vs_d <= 1'b0;
            acc_r   <= '0;
            acc_g   <= '0;
            acc_b   <= '0;
            snap_g  <= '0;
            snap_b  <= '0;
        end else begin
            in_vs_d <= in_vs;
            if (fs_c) begin
                snap_g <= acc_g;
                snap_b <= acc_b;
                acc_r  <= in_de ? SUM_W'(pix_r(in_data)) : '0;
                acc_g  <= in_de ? SUM_W'(pix_g(in_data)) : '0;
                acc_b  <= in_de ? SUM_W'(pix_b(in_data)) : '0;
            end else if (in_de) begin
                acc_r <= sat_add(acc_r, pix_r(in_data));
                acc_g <= sat_add(acc_g, pix_g(in_data));
                acc_b <= sat_add(acc_b, pix_b(in_data));
            end
        end
    end

    always_ff @(posedge pre_clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // The R division launches straight from the accumulators in the fs cycle,
    // which hold exactly the values being snapshotted.
    always_comb begin
        state_nx    = state;
        div_start_c = 1'b0;
        div_abort_c = 1'b0;
        hold_r_we_c = 1'b0;
        hold_b_we_c = 1'b0;
        pend_we_c   = 1'b0;
        dividend_c  = {snap_g, {FRAC_W{1'b0}}};
        divisor_c   = snap_b;
        if (fs_c) begin
            div_start_c = 1'b1;
            div_abort_c = (state != ST_IDLE);
            dividend_c  = {acc_g, {FRAC_W{1'b0}}};
            divisor_c   = acc_r;
            state_nx    = ST_DIV_R;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_DIV_R: begin
                    if (div_done) begin
                        hold_r_we_c = 1'b1;
                        div_start_c = 1'b1;
                        state_nx    = ST_DIV_B;
                    end
                end
                ST_DIV_B: begin
                    if (div_done) begin
                        hold_b_we_c = 1'b1;
                        state_nx    = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pend_we_c = 1'b1;
                    state_nx  = ST_IDLE;
                end
            endcase
        end
    end

    awb_gray_world_div u_div (
        .pre_clk  (pre_clk),
        .rst_n    (rst_n),
        .start    (div_start_c),
        .abort    (div_kill_c),
        .dividend (dividend_c),
        .divisor  (divisor_c),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q),
        .div_zero (div_zero)
    );

    // Gain bookkeeping: active gains only move at a frame start.
    always_ff @(posedge pre_clk) begin
        if (!rst_n) begin
            gain_r        <= GAIN_W'(GAIN_ONE);
            gain_b        <= GAIN_W'(GAIN_ONE);
            en_act        <= 1'b0;
            hold_r        <= GAIN_W'(GAIN_ONE);
            hold_b        <= GAIN_W'(GAIN_ONE);
            pending_r     <= GAIN_W'(GAIN_ONE);
            pending_b     <= GAIN_W'(GAIN_ONE);
            pending_valid <= 1'b0;
            div_abort     <= 1'b0;
        end else begin
            div_abort <= div_abort_c;
            if (fs_c) begin
                en_act        <= awb_en;
                pending_valid <= 1'b0;
                if (pending_valid) begin
                    gain_r <= pending_r;
                    gain_b <= pending_b;
                end
            end else if (pend_we_c) begin
                pending_r     <= hold_r;
                pending_b     <= hold_b;
                pending_valid <= 1'b1;
            end
            if (hold_r_we_c)
                hold_r <= clamp_gain(div_q, div_zero);
            if (hold_b_we_c)
                hold_b <= clamp_gain(div_q, div_zero);
        end
    end

    assign gr_c = en_act ? gain_r : GAIN_W'(GAIN_ONE);
    assign gb_c = en_act ? gain_b : GAIN_W'(GAIN_ONE);

    // Two-stage apply pipeline: multiply, then round/saturate.
    always_ff @(posedge pre_clk) begin
        if (!rst_n) begin
            s1_r     <= '0;
            s1_b     <= '0;
            s1_g     <= '0;
            s1_vs    <= 1'b0;
            s1_de    <= 1'b0;
            out_vs   <= 1'b0;
            out_de   <= 1'b0;
            out_data <= '0;
        end else begin
            s1_r     <= PROD_W'(pix_r(in_data)) * PROD_W'(gr_c);
            s1_b     <= PROD_W'(pix_b(in_data)) * PROD_W'(gb_c);
            s1_g     <= pix_g(in_data);
            s1_vs    <= in_vs;
            s1_de    <= in_de;
            out_vs   <= s1_vs;
            out_de   <= s1_de;
            out_data <= {sat8(s1_r), s1_g, sat8(s1_b)};
        end
    end

endmodule
